menu_cmd_encoder: RTL and testbench

- Sequential replacement for the combinational joypad-to-UART command logic in the display's menu path.
- Synchronises and debounces the joypad, detects button presses, and encodes them into menu command bytes.
- Queues commands in a small FIFO and drives the UART transmitter (async_transmitter, 25 MHz) with a proper start/busy handshake.
- Sits between the joypad input and the UART transmitter, next to text_menu_gen, which supplies cursor_y.

---
 rtl/menu_cmd_encoder_if.sv | 11 +
 rtl/menu_cmd_encoder.sv | 163 ++++++++++++++++
 tb/tb_menu_cmd_encoder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/menu_cmd_encoder_if.sv
// Transmit-side handshake between the menu command encoder and the UART transmitter.
// The encoder drives a one-cycle start strobe and the byte; the transmitter answers with busy.
// No buffering here; the transmitter's busy level is the only backpressure.
interface menu_cmd_encoder_if;
  logic       txd_start;
  logic [7:0] send_data;
  logic       txd_busy;

  modport master (output txd_start, output send_data, input txd_busy);
  modport slave  (input txd_start, input send_data, output txd_busy);
endinterface

// File: rtl/menu_cmd_encoder.sv
// Joypad-to-UART menu command encoder: synchronise, debounce, edge-detect, priority-encode, queue, transmit.
// Latency: a debounced rise is pushed the cycle after it is seen; txd_start follows 1 cycle after the FIFO is non-empty in IDLE.
// Backpressure: a full FIFO leaves the command pending in the mask; a repeat rise on a pending button is dropped and sets overflow.
module menu_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               menu_toggle,
  input  logic [7:0]         joypad,
  input  logic [4:0]         cursor_y,
  menu_cmd_encoder_if.master tx,
  output logic               cmd_pending,
  output logic               overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  // Pending-mask bit positions: a higher index wins the push.
  localparam int P_LEFT  = 0;
  localparam int P_RIGHT = 1;
  localparam int P_SEL   = 2;
  localparam int P_A     = 3;
  localparam int P_B     = 4;

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  logic [7:0]    sync1, sync2, cap, deb, agree;
  logic [CW-1:0] tick_cnt;
  logic          sample_tick;
  logic [4:0]    cmd_lvl, hist, rise, ev;
  logic [4:0]    pend, pend_keep, push_bit;
  logic [4:0]    sel_row;
  logic [7:0]    push_dat;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;
  state_t        state;
  logic [1:0]    wait_cnt;

  assign sample_tick = (tick_cnt == CNT_LAST);
  assign agree       = ~(cap ^ sync2);
  // Command-generating buttons reordered by priority: B, A, select, right, left.
  assign cmd_lvl     = {deb[1], deb[0], deb[2], deb[7], deb[6]};
  assign rise        = cmd_lvl & ~hist;
  // Select on row 0 is meaningless to the menu, so that rise is discarded outright.
  assign ev          = menu_toggle ? {rise[4:3], rise[2] & (cursor_y != 5'd0), rise[1:0]} : 5'd0;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop         = menu_toggle && (state == IDLE) && !fifo_empty && !tx.txd_busy;
  assign push        = menu_toggle && (pend != 5'd0) && (!fifo_full || pop);
  assign pend_keep   = push ? (pend & ~push_bit) : pend;

  // Pick the highest-priority pending command and its byte.
  always_comb begin
    push_bit = 5'd0;
    push_dat = 8'h00;
    if (pend[P_B]) begin
      push_bit[P_B] = 1'b1;
      push_dat      = 8'h82;
    end else if (pend[P_A]) begin
      push_bit[P_A] = 1'b1;
      push_dat      = 8'h83;
    end else if (pend[P_SEL]) begin
      push_bit[P_SEL] = 1'b1;
      push_dat        = {3'b000, sel_row};
    end else if (pend[P_RIGHT]) begin
      push_bit[P_RIGHT] = 1'b1;
      push_dat          = 8'h81;
    end else if (pend[P_LEFT]) begin
      push_bit[P_LEFT] = 1'b1;
      push_dat         = 8'h80;
    end
  end

  // Synchronise the joypad, sample it on each tick, and accept a level only after two matching samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 8'h00;
      sync2    <= 8'h00;
      cap      <= 8'h00;
      deb      <= 8'h00;
      tick_cnt <= '0;
      hist     <= 5'd0;
    end else begin
      sync1 <= joypad;
      sync2 <= sync1;
      hist  <= cmd_lvl;
      if (sample_tick) begin
        tick_cnt <= '0;
        cap      <= sync2;
        deb      <= (agree & sync2) | (~agree & deb);
      end else begin
        tick_cnt <= tick_cnt + CNT_ONE;
      end
    end
  end

  // Pending mask, overflow flag and command FIFO; leaving the menu flushes both mask and FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= 5'd0;
      sel_row  <= 5'd0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else if (!menu_toggle) begin
      pend   <= 5'd0;
      rd_ptr <= wr_ptr;
    end else begin
      pend <= pend_keep | ev;
      if ((ev & pend_keep) != 5'd0) overflow <= 1'b1;
      if (ev[P_SEL] && !pend_keep[P_SEL]) sel_row <= cursor_y;
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Transmit FSM: pop in IDLE, strobe once, then follow the transmitter's busy pulse (or give up after 4 cycles).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= 2'd0;
      tx.txd_start <= 1'b0;
      tx.send_data <= 8'h00;
    end else begin
      tx.txd_start <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          tx.send_data <= mem[rd_ptr[AW-1:0]];
          tx.txd_start <= 1'b1;
          state        <= START;
        end
        START: begin
          wait_cnt <= 2'd0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx.txd_busy)            state    <= WAIT_LO;
          else if (wait_cnt == 2'd3)  state    <= IDLE;
          else                        wait_cnt <= wait_cnt + 2'd1;
        end
        WAIT_LO: if (!tx.txd_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Anything queued or on the wire counts as pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cmd_pending <= 1'b0;
    else        cmd_pending <= !fifo_empty || (state != IDLE);
  end
endmodule

// File: tb/tb_menu_cmd_encoder.sv
// Randomised-bounce scoreboard bench for menu_cmd_encoder.
// Expected bytes come from a button-to-command model; a monitor pops them on every txd_start.
// A behavioural transmitter answers strobes with a configurable busy pulse, stuck-busy or no response.
module tb_menu_cmd_encoder;
  localparam int DEB   = 40;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       menu_toggle = 1'b0;
  logic [7:0] joypad = 8'h00;
  logic [4:0] cursor_y = 5'd0;
  logic       cmd_pending, overflow;

  menu_cmd_encoder_if tx_if();

  menu_cmd_encoder #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .menu_toggle(menu_toggle), .joypad(joypad),
    .cursor_y(cursor_y), .tx(tx_if), .cmd_pending(cmd_pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_strobes = 0;
  int busy_len = 10;
  bit busy_stuck = 1'b0;
  bit busy_ignore = 1'b0;
  int tx_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: each pressed button maps to one byte, emitted in B, A, select, right, left order.
  function automatic void expect_press(input logic [7:0] m);
    if (!menu_toggle) return;
    if (m[1]) exp_q.push_back(8'h82);
    if (m[0]) exp_q.push_back(8'h83);
    if (m[2] && cursor_y != 5'd0) exp_q.push_back({3'b000, cursor_y});
    if (m[7]) exp_q.push_back(8'h81);
    if (m[6]) exp_q.push_back(8'h80);
  endfunction

  // Monitor: every strobe must match the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (reset === 1'b1 && tx_if.txd_start === 1'b1) begin
      n_strobes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got send_data=%02h, expected no byte", tx_if.send_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_if.send_data !== e) begin
          n_fail++;
          $display("FAIL byte: got send_data=%02h, expected %02h", tx_if.send_data, e);
        end
      end
    end
  end

  // Behavioural UART transmitter.
  initial begin
    tx_if.txd_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_if.txd_start === 1'b1 && !busy_ignore) tx_cnt = busy_len;
      if (busy_stuck) tx_if.txd_busy = 1'b1;
      else if (tx_cnt > 0) begin
        tx_if.txd_busy = 1'b1;
        tx_cnt--;
      end else tx_if.txd_busy = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] m);
    joypad = joypad | m;
    cycles(3 * DEB);
    joypad = joypad & ~m;
    cycles(3 * DEB);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || cmd_pending !== 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    cycles(20);
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_idle"}, cmd_pending, 0);
  endtask

  task automatic wait_strobe(input string name, input int s0);
    int t;
    t = 0;
    while (n_strobes == s0 && t < 6 * DEB) begin
      @(negedge clk);
      t++;
    end
    check({name, "_strobe_seen"}, n_strobes - s0, 1);
  endtask

  initial begin
    int s0;
    #1 reset = 1'b0;
    cycles(3);
    check("reset_txd_start", tx_if.txd_start, 0);
    check("reset_send_data", tx_if.send_data, 0);
    check("reset_cmd_pending", cmd_pending, 0);
    check("reset_overflow", overflow, 0);
    reset = 1'b1;
    cycles(5);

    // Menu closed: presses are ignored; a button held across menu entry produces nothing.
    s0 = n_strobes;
    press(8'h01);
    joypad = 8'h01;
    cycles(3 * DEB);
    menu_toggle = 1'b1;
    cycles(3 * DEB);
    joypad = 8'h00;
    cycles(3 * DEB);
    check("menu_off_no_bytes", n_strobes - s0, 0);

    // Single left press.
    s0 = n_strobes;
    busy_len = 10;
    expect_press(8'h40);
    press(8'h40);
    wait_idle("single");
    check("single_count", n_strobes - s0, 1);

    // Bouncy A press and release, each bounce shorter than one sample period.
    s0 = n_strobes;
    expect_press(8'h01);
    for (int i = 0; i < 30; i++) begin
      joypad[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    joypad[0] = 1'b1;
    cycles(3 * DEB);
    for (int i = 0; i < 30; i++) begin
      joypad[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    joypad[0] = 1'b0;
    cycles(3 * DEB);
    wait_idle("bounce");
    check("bounce_count", n_strobes - s0, 1);

    // Short glitch on right never survives debounce.
    s0 = n_strobes;
    joypad[7] = 1'b1;
    cycles(3);
    joypad[7] = 1'b0;
    cycles(4 * DEB);
    check("glitch_count", n_strobes - s0, 0);

    // B, A, right together: priority order with a slow transmitter.
    s0 = n_strobes;
    busy_len = 50;
    expect_press(8'h83);
    press(8'h83);
    wait_idle("priority");
    check("priority_count", n_strobes - s0, 3);
    check("priority_no_overflow", overflow, 0);

    // Select encodes the captured cursor row; row 0 is discarded.
    s0 = n_strobes;
    busy_len = 10;
    cursor_y = 5'd7;
    expect_press(8'h04);
    press(8'h04);
    cursor_y = 5'd0;
    expect_press(8'h04);
    press(8'h04);
    cursor_y = 5'd31;
    expect_press(8'h04);
    press(8'h04);
    wait_idle("select");
    check("select_count", n_strobes - s0, 2);

    // Transmitter misses strobes: FSM gives up and carries on.
    s0 = n_strobes;
    busy_ignore = 1'b1;
    expect_press(8'h80);
    press(8'h80);
    expect_press(8'h40);
    press(8'h40);
    wait_idle("missed_busy");
    check("missed_busy_count", n_strobes - s0, 2);
    busy_ignore = 1'b0;

    // Stuck transmitter: four left presses fill the FIFO, a fifth stays pending, a sixth overflows.
    s0 = n_strobes;
    busy_stuck = 1'b1;
    cycles(4);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expect_press(8'h40);
      press(8'h40);
      if (i == 4) check("overflow_before_sixth", overflow, 0);
    end
    check("overflow_after_sixth", overflow, 1);
    check("stuck_cmd_pending", cmd_pending, 1);
    check("stuck_no_strobe", n_strobes - s0, 0);
    busy_stuck = 1'b0;
    wait_idle("wrap");
    check("wrap_count", n_strobes - s0, 5);
    check("overflow_sticky", overflow, 1);

    // Menu exit with one byte on the wire and three queued: only the in-flight byte goes out.
    s0 = n_strobes;
    busy_len = 60;
    exp_q.push_back(8'h82);
    joypad = 8'hC3;
    wait_strobe("menu_exit", s0);
    cycles(10);
    check("exit_inflight_pending", cmd_pending, 1);
    menu_toggle = 1'b0;
    cycles(2 * DEB);
    joypad = 8'h00;
    cycles(3 * DEB);
    wait_idle("menu_exit");
    check("menu_exit_count", n_strobes - s0, 1);
    check("menu_exit_overflow_kept", overflow, 1);
    menu_toggle = 1'b1;
    cycles(3 * DEB);
    check("menu_reentry_count", n_strobes - s0, 1);

    // Asynchronous reset during WAIT_LO clears outputs before any clock edge.
    s0 = n_strobes;
    exp_q.push_back(8'h82);
    joypad = 8'h02;
    wait_strobe("reset_mid", s0);
    cycles(10);
    check("pre_reset_send_data", tx_if.send_data, 8'h82);
    check("pre_reset_cmd_pending", cmd_pending, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_reset_txd_start", tx_if.txd_start, 0);
    check("async_reset_send_data", tx_if.send_data, 0);
    check("async_reset_cmd_pending", cmd_pending, 0);
    check("async_reset_overflow", overflow, 0);
    joypad = 8'h00;
    cycles(3 * DEB);
    reset = 1'b1;
    s0 = n_strobes;
    cycles(4 * DEB);
    check("post_reset_silent", n_strobes - s0, 0);
    check("post_reset_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end
endmodule
